// File: rtl/seqdetect_pkg.sv
// Shared types and constants for the sequence-detector serial feeder.
package seqdetect_pkg;

    // Two-state shifter: waiting for a word, or emitting one
    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Line value while no data is pending; 0 never begins a detector match
    localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seqdetect_ser_fifo.sv
// Small synchronous word FIFO with async reset. Pointers wrap naturally
// because the depth is a power of two. Read data is combinational from the
// head entry so the consumer can load on the same edge it pops.
module seqdetect_ser_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DATA_W-1:0]               wdata,
    output logic [DATA_W-1:0]               rdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            full,
    output logic                            empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/seqdetect_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Words arrive over
// valid/ready into a FIFO, then are shifted out one bit per clock with no
// gap between back-to-back words. Idle cycles drive 0 with out_valid low.
module seqdetect_serializer
    import seqdetect_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            out_bit,
    output logic                            out_valid,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    localparam int BC_W = $clog2(DATA_W);

    ser_state_t        state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic              out_bit_q, out_valid_q;

    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic              push, load;
    logic              first_bit, next_bit;
    logic [DATA_W-1:0] load_rest, shift_rest;

    // Ready depends only on registered occupancy and reset, never on in_valid
    assign in_ready = ~fifo_full & ~reset;
    assign push     = in_valid & in_ready;

    // The shifter takes a new word when idle, or right after its last bit
    assign load = ~fifo_empty & ((state_q == SER_IDLE) || (bit_cnt_q == '0));

    // Bit-order selection: shreg_q keeps the bits still to be emitted,
    // with the next one at the exit end
    assign first_bit  = MSB_FIRST ? fifo_rdata[DATA_W-1] : fifo_rdata[0];
    assign load_rest  = MSB_FIRST ? (fifo_rdata << 1) : (fifo_rdata >> 1);
    assign next_bit   = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
    assign shift_rest = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    seqdetect_ser_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Shifter FSM with registered serial outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SER_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            out_bit_q   <= SER_IDLE_BIT;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                SER_IDLE: begin
                    if (load) begin
                        state_q     <= SER_SHIFT;
                        shreg_q     <= load_rest;
                        bit_cnt_q   <= BC_W'(DATA_W-1);
                        out_bit_q   <= first_bit;
                        out_valid_q <= 1'b1;
                    end
                end
                SER_SHIFT: begin
                    if (bit_cnt_q != '0) begin
                        shreg_q   <= shift_rest;
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                        out_bit_q <= next_bit;
                    end else if (load) begin
                        // Chain straight into the next word, no idle cycle
                        shreg_q     <= load_rest;
                        bit_cnt_q   <= BC_W'(DATA_W-1);
                        out_bit_q   <= first_bit;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q     <= SER_IDLE;
                        out_bit_q   <= SER_IDLE_BIT;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= SER_IDLE;
            endcase
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == SER_SHIFT) | (fifo_count != '0);

endmodule
